// File: rtl/poly_driver.sv
// Initiator for a serial polynomial evaluator: loads A, B, C, X over the Go/DataOut
// strobe protocol, then waits (with timeout) for the evaluator's result.
module poly_driver #(
  parameter int GO_CYCLES  = 2,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 32
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] C,
  input  logic [7:0] X,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [7:0] Result,
  output logic       Go,
  output logic [7:0] DataOut,
  input  logic       ResultValid,
  input  logic [7:0] DataResult
);

  localparam logic [3:0] GO_LAST   = 4'(GO_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    GO_HI,
    GO_LO,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  state_t     state_reg;
  logic [1:0] idx_reg;
  logic [3:0] phase_reg;
  logic [7:0] wait_reg;
  logic       go_reg;
  logic [7:0] dout_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       error_reg;
  logic [7:0] result_reg;

  logic [7:0] op_in  [4];
  logic [7:0] op_reg [4];
  logic       accept;
  logic [1:0] idx_inc;

  assign op_in[0] = A;
  assign op_in[1] = B;
  assign op_in[2] = C;
  assign op_in[3] = X;

  assign accept  = (state_reg == IDLE) && Start;
  assign idx_inc = idx_reg + 2'd1;

  // Operands are frozen at acceptance so later port changes cannot leak in.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_op
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          op_reg[gi] <= 8'd0;
        end else if (accept) begin
          op_reg[gi] <= op_in[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg  <= IDLE;
      idx_reg    <= 2'd0;
      phase_reg  <= 4'd0;
      wait_reg   <= 8'd0;
      go_reg     <= 1'b0;
      dout_reg   <= 8'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      error_reg  <= 1'b0;
      result_reg <= 8'd0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            state_reg <= SETUP;
            idx_reg   <= 2'd0;
            busy_reg  <= 1'b1;
            dout_reg  <= A;
          end
        end
        SETUP: begin
          state_reg <= GO_HI;
          go_reg    <= 1'b1;
          phase_reg <= 4'd0;
        end
        GO_HI: begin
          if (phase_reg == GO_LAST) begin
            state_reg <= GO_LO;
            go_reg    <= 1'b0;
            phase_reg <= 4'd0;
          end else begin
            phase_reg <= phase_reg + 4'd1;
          end
        end
        GO_LO: begin
          if (phase_reg == GAP_LAST) begin
            phase_reg <= 4'd0;
            if (idx_reg == 2'd3) begin
              state_reg <= WAIT_LOW;
              wait_reg  <= 8'd0;
              dout_reg  <= 8'd0;
            end else begin
              state_reg <= SETUP;
              idx_reg   <= idx_inc;
              dout_reg  <= op_reg[idx_inc];
            end
          end else begin
            phase_reg <= phase_reg + 4'd1;
          end
        end
        // A valid flag still high here belongs to the previous evaluation.
        WAIT_LOW: begin
          wait_reg <= wait_reg + 8'd1;
          if (wait_reg == WAIT_LAST) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            error_reg <= 1'b1;
          end else if (!ResultValid) begin
            state_reg <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          wait_reg <= wait_reg + 8'd1;
          if (ResultValid) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            result_reg <= DataResult;
          end else if (wait_reg == WAIT_LAST) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            error_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          go_reg    <= 1'b0;
          dout_reg  <= 8'd0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_reg;
  assign Done    = done_reg;
  assign Error   = error_reg;
  assign Result  = result_reg;
  assign Go      = go_reg;
  assign DataOut = dout_reg;

endmodule

// File: tb/tb_poly_driver.sv
// Bench for poly_driver: evaluator model, spec-level expected-result queue with a
// per-cycle protocol/result monitor, and directed scenarios with literal results.
module tb_poly_driver;

  localparam int GO_CYCLES  = 2;
  localparam int GAP_CYCLES = 1;
  localparam int TIMEOUT    = 32;
  localparam int LOAD_CYCLES = 4 * (1 + GO_CYCLES + GAP_CYCLES);

  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] A = 8'd0, B = 8'd0, C = 8'd0, X = 8'd0;
  logic       Busy, Done, Error, Go;
  logic [7:0] Result, DataOut;
  logic       ResultValid;
  logic [7:0] DataResult;

  always #5 Clock = ~Clock;

  poly_driver #(
    .GO_CYCLES (GO_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .A          (A),
    .B          (B),
    .C          (C),
    .X          (X),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error),
    .Result     (Result),
    .Go         (Go),
    .DataOut    (DataOut),
    .ResultValid(ResultValid),
    .DataResult (DataResult)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic [7:0] poly(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] x);
    int v;
    v = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
    return v[7:0];
  endfunction

  // Evaluator model: captures DataOut on each Go rise; after the 4th operand the old
  // valid flag lingers for ev_drop cycles, and the new result appears at ev_rise.
  int         ev_drop = 5;
  int         ev_rise = 8;
  bit         ev_tie_low = 1'b0;
  logic [7:0] ev_ops [4];
  int         ev_idx;
  int         ev_age;
  bit         ev_active;
  logic       ev_go_prev;
  logic [7:0] load_q [$];

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ev_idx      = 0;
      ev_age      = 0;
      ev_active   = 1'b0;
      ev_go_prev  = 1'b0;
      ResultValid <= 1'b0;
      DataResult  <= 8'd0;
    end else begin
      if (Go && !ev_go_prev) begin
        ev_ops[ev_idx] = DataOut;
        load_q.push_back(DataOut);
        if (ev_idx == 3) begin
          ev_idx    = 0;
          ev_active = 1'b1;
          ev_age    = 0;
        end else begin
          ev_idx++;
        end
      end else if (ev_active) begin
        ev_age++;
        if (ev_age == ev_drop) ResultValid <= 1'b0;
        if (ev_age == ev_rise) begin
          if (!ev_tie_low) begin
            ResultValid <= 1'b1;
            DataResult  <= poly(ev_ops[0], ev_ops[1], ev_ops[2], ev_ops[3]);
          end
          ev_active = 1'b0;
        end
      end
      ev_go_prev = Go;
    end
  end

  // Expected completions, in order; err=1 means the prior Result must be kept.
  typedef struct {
    bit         err;
    logic [7:0] res;
  } exp_t;
  exp_t exp_q [$];

  logic [7:0] model_result = 8'd0;
  bit         mon_go_prev = 1'b0;
  logic [7:0] mon_dout_prev = 8'd0;
  int         go_run = 0;
  int         gap_run = 0;
  int         pulse_n = 0;

  always @(negedge Clock) begin
    if (!Resetn) begin
      check("rst_go", Go, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_error", Error, 0);
      check("rst_dout", DataOut, 0);
      check("rst_result", Result, 0);
      model_result  = 8'd0;
      mon_go_prev   = 1'b0;
      mon_dout_prev = 8'd0;
      go_run        = 0;
      gap_run       = 0;
      pulse_n       = 0;
    end else begin
      if (!Busy) begin
        check("idle_go", Go, 0);
        check("idle_dout", DataOut, 0);
      end
      if (Go || mon_go_prev) check("dout_stable", DataOut, mon_dout_prev);
      if (Go && !mon_go_prev) begin
        if (pulse_n > 0) check("gap_width", gap_run, GAP_CYCLES + 1);
        pulse_n++;
      end
      if (Go) begin
        go_run++;
        gap_run = 0;
      end else begin
        gap_run++;
        if (mon_go_prev) begin
          check("go_width", go_run, GO_CYCLES);
          go_run = 0;
        end
      end
      check("error_qual", Error & ~Done, 0);
      if (Done) begin
        check("go_pulses", pulse_n, 4);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done=1 error=%0d result=%0d, expected no Done", Error, Result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_error", Error, e.err);
          if (!e.err) model_result = e.res;
          check("done_result", Result, model_result);
          $display("txn complete: error=%0d result=%0d", Error, Result);
        end
      end else begin
        check("result_hold", Result, model_result);
      end
      if (!Busy) pulse_n = 0;
      mon_go_prev   = Go;
      mon_dout_prev = DataOut;
    end
  end

  task automatic push_exp(input bit err, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] x);
    exp_t e;
    e.err = err;
    e.res = poly(a, b, c, x);
    exp_q.push_back(e);
  endtask

  // Called at a negedge while the DUT is in IDLE; returns one cycle after acceptance.
  task automatic start_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] x);
    load_q.delete();
    A = a; B = b; C = c; X = x;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check("accept_busy", Busy, 1);
  endtask

  task automatic wait_done(input int max_cycles, output int cyc);
    cyc = 0;
    while (!Done && cyc < max_cycles) begin
      @(negedge Clock);
      cyc++;
    end
    if (!Done) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no Done within %0d cycles, expected Done", max_cycles);
    end
  endtask

  task automatic check_loads(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] x);
    logic [7:0] want [4];
    want[0] = a; want[1] = b; want[2] = c; want[3] = x;
    check("load_count", load_q.size(), 4);
    for (int i = 0; i < 4 && i < load_q.size(); i++) check("load_data", load_q[i], want[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    #1 Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    @(posedge Clock);
    #2 Resetn = 1'b1;
    @(negedge Clock);
    check("post_reset_busy", Busy, 0);
    check("post_reset_result", Result, 0);
    repeat (5) @(negedge Clock);
    check("idle_without_start", Busy, 0);

    // Basic evaluation, Result = 4 + 4 + 3.
    push_exp(0, 1, 2, 3, 2);
    start_txn(1, 2, 3, 2);
    wait_done(100, cyc);
    check("s1_result", Result, 11);
    check("s1_error", Error, 0);
    check_loads(1, 2, 3, 2);
    repeat (2) @(negedge Clock);

    // Result wraps: 300 mod 256.
    push_exp(0, 3, 0, 0, 10);
    start_txn(3, 0, 0, 10);
    wait_done(100, cyc);
    check("s2_result", Result, 44);
    check_loads(3, 0, 0, 10);
    repeat (2) @(negedge Clock);

    // Back-to-back: second Start in the Done cycle, stale valid flag still high.
    push_exp(0, 1, 2, 3, 2);
    start_txn(1, 2, 3, 2);
    wait_done(100, cyc);
    check("s3a_result", Result, 11);
    push_exp(0, 0, 1, 5, 4);
    start_txn(0, 1, 5, 4);
    wait_done(100, cyc);
    check("s3b_result", Result, 9);
    check_loads(0, 1, 5, 4);
    repeat (2) @(negedge Clock);

    // Timeout: valid never rises; Done+Error TIMEOUT cycles after WAIT_LOW entry.
    ev_tie_low = 1'b1;
    push_exp(1, 5, 6, 7, 8);
    start_txn(5, 6, 7, 8);
    wait_done(200, cyc);
    check("s4_latency", cyc, LOAD_CYCLES + TIMEOUT);
    check("s4_error", Error, 1);
    check("s4_result_kept", Result, 9);
    ev_tie_low = 1'b0;
    repeat (2) @(negedge Clock);

    // Valid arriving in the final wait cycle wins over the timeout.
    ev_rise = 33;
    push_exp(0, 2, 3, 4, 5);
    start_txn(2, 3, 4, 5);
    wait_done(200, cyc);
    check("s5_latency", cyc, 48);
    check("s5_error", Error, 0);
    check("s5_result", Result, 69);
    repeat (2) @(negedge Clock);

    // One cycle later than that is a timeout.
    ev_rise = 34;
    push_exp(1, 7, 7, 7, 7);
    start_txn(7, 7, 7, 7);
    wait_done(200, cyc);
    check("s6_latency", cyc, 48);
    check("s6_error", Error, 1);
    check("s6_result_kept", Result, 69);
    ev_rise = 8;
    repeat (4) @(negedge Clock);

    // Start and operand changes while busy are ignored.
    push_exp(0, 4, 3, 2, 6);
    start_txn(4, 3, 2, 6);
    for (int i = 0; i < 8; i++) begin
      A = 8'($urandom); B = 8'($urandom); C = 8'($urandom); X = 8'($urandom);
      Start = (i % 2 == 0);
      @(negedge Clock);
    end
    Start = 1'b0;
    wait_done(100, cyc);
    check("s7_result", Result, 164);
    check_loads(4, 3, 2, 6);
    repeat (40) @(negedge Clock);
    check("s7_no_second_txn", Busy, 0);

    // Reset during the second GO_HI aborts cleanly.
    start_txn(9, 8, 7, 6);
    repeat (5) @(posedge Clock);
    #2;
    check("s8_in_go_hi", Go, 1);
    Resetn = 1'b0;
    #1;
    check("s8_rst_go", Go, 0);
    check("s8_rst_busy", Busy, 0);
    check("s8_rst_done", Done, 0);
    repeat (2) @(posedge Clock);
    #2 Resetn = 1'b1;
    repeat (30) @(negedge Clock);
    check("s8_stays_idle", Busy, 0);
    push_exp(0, 1, 1, 1, 3);
    start_txn(1, 1, 1, 3);
    wait_done(100, cyc);
    check("s8_result", Result, 13);
    check_loads(1, 1, 1, 3);
    repeat (3) @(negedge Clock);

    check("exp_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_driver.md
POLY_DRIVER -- requirements
Module: poly_driver

Interface
REQ-001 SHALL have parameter GO_CYCLES, default 2: cycles Go is held high per operand (legal range 1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 1: cycles Go is held low after each Go pulse (legal range 1..15).
REQ-003 SHALL have parameter TIMEOUT, default 32: maximum cycles spent waiting for the result (legal range 8..255).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports named as follows:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous reset, active low.
REQ-005 SHALL have the following request ports:
- Start  in  1  request; sampled only in IDLE.
- A, B, C, X  in  8 each  polynomial operands.
REQ-006 SHALL have the following status ports:
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  qualifies Done; high means timeout.
- Result  out  8  captured result, valid while Done=1 and until the next Done.
REQ-007 SHALL have the following evaluator-side ports:
- Go  out  1  evaluator load strobe.
- DataOut  out  8  evaluator data input.
- ResultValid  in  1  evaluator result-valid flag.
- DataResult  in  8  evaluator result.

Function
REQ-008 The block SHALL be the initiator of the serial Go/DataIn load protocol and SHALL deliver operands in the order A, B, C, X.
REQ-009 Its function is to obtain Result = (A*X*X + B*X + C) mod 256 from the evaluator; the block itself performs no arithmetic.
REQ-010 States SHALL be IDLE, SETUP, GO_HI, GO_LO, WAIT_LOW and WAIT_HIGH.
REQ-011 In IDLE with Start=1, the block SHALL copy A, B, C and X into internal registers, clear the 2-bit operand index, and enter SETUP on the next edge.
REQ-012 In IDLE with Start=0, the block SHALL stay in IDLE.
REQ-013 Start SHALL be ignored while Busy=1, and operand port changes after acceptance SHALL have no effect.
REQ-014 SETUP SHALL last 1 cycle with Go=0 and DataOut equal to the operand selected by the index, then go to GO_HI.
REQ-015 GO_HI SHALL last exactly GO_CYCLES cycles with Go=1 and DataOut held, then go to GO_LO.
REQ-016 GO_LO SHALL last exactly GAP_CYCLES cycles with Go=0 and DataOut held.
REQ-017 On exit from GO_LO, the block SHALL go to SETUP with the index incremented when the index is below 3, and to WAIT_LOW when the index equals 3.
REQ-018 DataOut SHALL never change in a cycle where Go=1 or in the cycle Go falls.
REQ-019 DataOut SHALL be 0 in IDLE, WAIT_LOW and WAIT_HIGH.
REQ-020 The wait counter SHALL clear on entry to WAIT_LOW and increment every cycle in WAIT_LOW and WAIT_HIGH.
REQ-021 WAIT_LOW SHALL stay until ResultValid=0 and then go to WAIT_HIGH; this discards the stale valid flag left by a previous evaluation.
REQ-022 In WAIT_HIGH with ResultValid=1, the block SHALL capture Result<=DataResult, pulse Done=1 with Error=0 for one cycle, and return to IDLE.
REQ-023 If the wait counter reaches TIMEOUT in either wait state, the block SHALL pulse Done=1 with Error=1, leave Result unchanged, and return to IDLE.
REQ-024 When ResultValid rises in the same cycle the counter reaches TIMEOUT, the capture SHALL take priority (Error=0).
REQ-025 Done and Error SHALL be registered and assert in the first IDLE cycle.
REQ-026 Start SHALL be accepted in that same first IDLE cycle, so back-to-back requests are legal.
REQ-027 Error SHALL be 0 whenever Done=0.
REQ-028 Go SHALL never be high outside GO_HI.

Reset
REQ-029 When Resetn=0, the block SHALL asynchronously force state=IDLE, index=0, wait counter=0 and operand registers=0.
REQ-030 When Resetn=0, the block SHALL asynchronously force Go=0, DataOut=0, Busy=0, Done=0, Error=0 and Result=0.
REQ-031 Reset asserted mid-transaction SHALL drop Go in the same cycle without completing the transaction or pulsing Done.
REQ-032 After Resetn deasserts, the block SHALL remain in IDLE until Start=1 is sampled.

Verification
REQ-033 Use the default parameters, Resetn released, and the evaluator model attached for all scenarios; each scenario SHALL check the responses below:
- Start with A=1, B=2, C=3, X=2 -> four Go pulses, each 2 cycles high, with DataOut 1, 2, 3, 2 stable across each pulse -> Done=1, Error=0, Result=11.
- Start with A=3, B=0, C=0, X=10 -> Result=44 (300 mod 256).
- Two back-to-back requests, the second issued in the Done cycle with A=0, B=1, C=5, X=4 -> second Done with Result=9, and WAIT_LOW ignores the stale ResultValid=1.
- ResultValid tied to 0 -> Done=1 and Error=1 exactly TIMEOUT cycles after entering WAIT_LOW, and Result keeps its prior value.
- Start pulsed again while Busy=1, and operand ports changed mid-transaction -> no effect, and Result comes from the originally latched operands.
- Resetn pulsed low during the second GO_HI -> Go=0 and Busy=0 immediately, no Done, and a following Start runs a clean transaction.
